// File: rtl/alu_pkg.sv
// Package for the ALU logic unit.
//   ALU_WIDTH    : operand / result width of the logic unit
//   ALU_SEL_*    : 2-bit opcode encodings selecting the logic result
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    localparam logic [1:0] ALU_SEL_AND  = 2'b00;
    localparam logic [1:0] ALU_SEL_OR   = 2'b01;
    localparam logic [1:0] ALU_SEL_XOR  = 2'b10;
    localparam logic [1:0] ALU_SEL_XNOR = 2'b11;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational status flags for one WIDTH-bit value.
//   value    in   WIDTH  value to inspect
//   zero     out  1      value == 0
//   all_ones out  1      value == all ones
//   parity   out  1      even-parity XOR-reduce (only with RESULT_PARITY_EN)
// Optional feature macro: RESULT_PARITY_EN.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic             zero,
`ifdef RESULT_PARITY_EN
    output logic             parity,
`endif
    output logic             all_ones
);

    assign zero     = (value == '0);
    assign all_ones = &value;
`ifdef RESULT_PARITY_EN
    assign parity   = ^value;
`endif

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage of the ALU logic unit.
// Selects one of four logic results by sel, registers it with flags and
// presents it on a valid/ready handshake. A skid entry behind the output
// register lets the stage accept one more input while downstream stalls,
// so in_ready depends only on registered state.
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    input handshake
//   sel                  00 AND, 01 OR, 10 XOR, 11 XNOR
//   and_res..xnor_res    parallel logic-unit results
//   out_valid/out_ready  output handshake
//   result, zero, all_ones, parity   registered result and flags
//   op_count             accepted-transfer counter, wraps
// Optional feature macro: RESULT_PARITY_EN (adds the parity output).
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] xor_res,
    input  logic [WIDTH-1:0] xnor_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             all_ones,
`ifdef RESULT_PARITY_EN
    output logic             parity,
`endif
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] mux_val;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             zero_q,      zero_d;
    logic             ones_q,      ones_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_val_q,   skid_val_d;
    logic             skid_zero_q,  skid_zero_d;
    logic             skid_ones_q,  skid_ones_d;
    logic [CNT_W-1:0] op_count_q,   op_count_d;

    // Flags of the incoming value, one copy travelling with the skid entry
    // and one feeding the direct output-register load.
    logic             sk_zero, sk_ones, ld_zero, ld_ones;

`ifdef RESULT_PARITY_EN
    logic             parity_q, parity_d;
    logic             skid_par_q, skid_par_d;
    logic             sk_par, ld_par;
`endif

    always_comb begin
        case (sel)
            ALU_SEL_AND: mux_val = and_res;
            ALU_SEL_OR:  mux_val = or_res;
            ALU_SEL_XOR: mux_val = xor_res;
            default:     mux_val = xnor_res;
        endcase
    end

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_skid (
        .value    (mux_val),
        .zero     (sk_zero),
`ifdef RESULT_PARITY_EN
        .parity   (sk_par),
`endif
        .all_ones (sk_ones)
    );

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_load (
        .value    (mux_val),
        .zero     (ld_zero),
`ifdef RESULT_PARITY_EN
        .parity   (ld_par),
`endif
        .all_ones (ld_ones)
    );

    // Skid occupancy is the only thing that blocks input; reset also blocks.
    assign in_ready = !skid_valid_q && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        ones_d       = ones_q;
        skid_valid_d = skid_valid_q;
        skid_val_d   = skid_val_q;
        skid_zero_d  = skid_zero_q;
        skid_ones_d  = skid_ones_q;
`ifdef RESULT_PARITY_EN
        parity_d     = parity_q;
        skid_par_d   = skid_par_q;
`endif
        op_count_d   = op_count_q + CNT_W'(accept);

        if (!out_valid_q || out_ready) begin
            // Output register free this cycle: skid has priority (FULL),
            // otherwise take the new input directly.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                result_d     = skid_val_q;
                zero_d       = skid_zero_q;
                ones_d       = skid_ones_q;
`ifdef RESULT_PARITY_EN
                parity_d     = skid_par_q;
`endif
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                result_d     = mux_val;
                zero_d       = ld_zero;
                ones_d       = ld_ones;
`ifdef RESULT_PARITY_EN
                parity_d     = ld_par;
`endif
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            // Output held by a stall: park the new entry in the skid.
            skid_valid_d = 1'b1;
            skid_val_d   = mux_val;
            skid_zero_d  = sk_zero;
            skid_ones_d  = sk_ones;
`ifdef RESULT_PARITY_EN
            skid_par_d   = sk_par;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            ones_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_val_q   <= '0;
            skid_zero_q  <= 1'b0;
            skid_ones_q  <= 1'b0;
            op_count_q   <= '0;
`ifdef RESULT_PARITY_EN
            parity_q     <= 1'b0;
            skid_par_q   <= 1'b0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            ones_q       <= ones_d;
            skid_valid_q <= skid_valid_d;
            skid_val_q   <= skid_val_d;
            skid_zero_q  <= skid_zero_d;
            skid_ones_q  <= skid_ones_d;
            op_count_q   <= op_count_d;
`ifdef RESULT_PARITY_EN
            parity_q     <= parity_d;
            skid_par_q   <= skid_par_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign all_ones  = ones_q;
    assign op_count  = op_count_q;
`ifdef RESULT_PARITY_EN
    assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: table-driven vectors, hand-written stall /
// reset sequences and a scoreboard-backed occupancy model checked every cycle.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int W  = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    sel = 2'b00;
    logic [W-1:0]  and_res = '0, or_res = '0, xor_res = '0, xnor_res = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero, all_ones;
    logic [CW-1:0] op_count;
`ifdef RESULT_PARITY_EN
    logic          parity;
`endif

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .and_res   (and_res),
        .or_res    (or_res),
        .xor_res   (xor_res),
        .xnor_res  (xnor_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .all_ones  (all_ones),
`ifdef RESULT_PARITY_EN
        .parity    (parity),
`endif
        .op_count  (op_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        logic         p;
    } exp_t;

    exp_t          sb[$];
    int            occ = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          m_acc, m_drn;
    exp_t          m_front;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] s, input logic [W-1:0] a,
                                   input logic [W-1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] n);
        exp_t e;
        logic [W-1:0] v;
        if (s == 2'b00)      v = a;
        else if (s == 2'b01) v = o;
        else if (s == 2'b10) v = x;
        else                 v = n;
        e.res = v;
        e.z   = (v == 0);
        e.o   = (v == {W{1'b1}});
        e.p   = ^v;
        return e;
    endfunction

    // Occupancy model + scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("in_ready_in_reset", in_ready, 0);
            sb.delete();
            occ = 0;
            exp_cnt = '0;
        end else begin
            chk("out_valid", out_valid, occ > 0);
            chk("in_ready", in_ready, occ < 2);
            chk("op_count", op_count, exp_cnt);
            if (occ > 0) begin
                m_front = sb[0];
                chk("sb_result", result, m_front.res);
                chk("sb_zero", zero, m_front.z);
                chk("sb_all_ones", all_ones, m_front.o);
`ifdef RESULT_PARITY_EN
                chk("sb_parity", parity, m_front.p);
`endif
            end
            m_acc = in_valid && (occ < 2);
            m_drn = (occ > 0) && out_ready;
            if (m_drn) begin
                void'(sb.pop_front());
                occ--;
            end
            if (m_acc) begin
                sb.push_back(model(sel, and_res, or_res, xor_res, xnor_res));
                occ++;
                exp_cnt++;
            end
        end
    end

    typedef struct {
        logic [1:0]   s;
        logic [W-1:0] a, o, x, n;
        logic [W-1:0] res;
        logic         z, ones, p;
    } vec_t;

    vec_t tbl[6];

    task automatic drive(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] n);
        sel = s; and_res = a; or_res = o; xor_res = x; xnor_res = n;
    endtask

    logic [CW-1:0] cnt_snap;

    initial begin
        tbl[0] = '{2'b11, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h3F, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{2'b00, 6'h00, 6'h15, 6'h2A, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 6'h3F, 6'h07, 6'h00, 6'h00, 6'h07, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{2'b10, 6'h01, 6'h02, 6'h2A, 6'h04, 6'h2A, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2'b11, 6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{2'b00, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_all_ones", all_ones, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef RESULT_PARITY_EN
        chk("rst_parity", parity, 0);
`endif

        // table vectors, one transfer each, checked one cycle after accept
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            drive(tbl[i].s, tbl[i].a, tbl[i].o, tbl[i].x, tbl[i].n);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_result", result, tbl[i].res);
            chk("tbl_zero", zero, tbl[i].z);
            chk("tbl_all_ones", all_ones, tbl[i].ones);
            chk("tbl_op_count", op_count, i + 1);
`ifdef RESULT_PARITY_EN
            chk("tbl_parity", parity, tbl[i].p);
`endif
        end

        // stall: A then B accepted while out_ready=0
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b01, 6'h00, 6'h12, 6'h00, 6'h00);    // A = 12
        @(posedge clk); #1;
        drive(2'b10, 6'h00, 6'h00, 6'h21, 6'h00);    // B = 21
        @(posedge clk); #1;
        drive(2'b11, 6'h00, 6'h00, 6'h00, 6'h0F);    // C, must be ignored
        @(negedge clk);
        cnt_snap = op_count;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_result_a", result, 6'h12);
        chk("stall_count", cnt_snap, 8);
        repeat (2) begin
            @(negedge clk);
            chk("blocked_result_a", result, 6'h12);
            chk("blocked_op_count", op_count, cnt_snap);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_a", result, 6'h12);
        @(negedge clk);
        chk("drain_b", result, 6'h21);
        chk("drain_in_ready", in_ready, 1);
        @(negedge clk);
        chk("drain_empty", out_valid, 0);

        // reset while FULL
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b00, 6'h33, 6'h00, 6'h00, 6'h00);
        @(posedge clk); #1;
        drive(2'b01, 6'h00, 6'h0C, 6'h00, 6'h00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_before_reset", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_op_count", op_count, 0);
        chk("post_rst_in_ready", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_entry", out_valid, 0);
        end

        // streaming, 300 transfers from op_count 0
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            drive(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_op_count", op_count, 44);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
